// File: rtl/pipelined_multiplier.sv
// Purpose : Unsigned shift-add multiplier, one partial product per pipeline
//           stage, with valid/ready handshake and a global stall.
// Ports   : clk, reset        - clock, asynchronous active-high reset
//           in_valid/in_ready - operand handshake (in_ready is combinational)
//           multiplicand      - MULTIPLICANDLEN-bit unsigned operand
//           multiplier        - MULTIPLIERLEN-bit unsigned operand
//           out_valid/out_ready - product handshake
//           product           - PRODUCTLEN-bit result from the final stage
//           inflight          - number of stages currently holding a valid op
module pipelined_multiplier #(
   parameter int unsigned MULTIPLICANDLEN = 8,
   parameter int unsigned MULTIPLIERLEN   = 8
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       in_valid,
   output logic                                       in_ready,
   input  logic [MULTIPLICANDLEN-1:0]                 multiplicand,
   input  logic [MULTIPLIERLEN-1:0]                   multiplier,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   output logic [MULTIPLICANDLEN+MULTIPLIERLEN-1:0]   product,
   output logic [$clog2(MULTIPLIERLEN+1)-1:0]         inflight
);

   localparam int unsigned PRODUCTLEN = MULTIPLICANDLEN + MULTIPLIERLEN;
   localparam int unsigned NSTAGE     = MULTIPLIERLEN;
   localparam int unsigned CNTW       = $clog2(MULTIPLIERLEN + 1);

   // Whole pipeline moves together; any hold at the output freezes every stage.
   logic w_advance;
   assign w_advance = !out_valid || out_ready;
   assign in_ready  = w_advance;

   for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      logic                       r_valid;
      logic [PRODUCTLEN-1:0]      r_acc;
      logic [MULTIPLICANDLEN-1:0] r_mcand;
      logic [MULTIPLIERLEN-1:0]   r_mplier;

      logic                       w_prev_valid;
      logic [PRODUCTLEN-1:0]      w_prev_acc;
      logic [MULTIPLICANDLEN-1:0] w_prev_mcand;
      logic [MULTIPLIERLEN-1:0]   w_prev_mplier;
      logic [PRODUCTLEN-1:0]      w_addend;

      // Stage 0 starts from the raw operands and a zero accumulator.
      if (k == 0) begin : g_first
         assign w_prev_valid  = in_valid;
         assign w_prev_acc    = '0;
         assign w_prev_mcand  = multiplicand;
         assign w_prev_mplier = multiplier;
      end else begin : g_chain
         assign w_prev_valid  = g_stage[k-1].r_valid;
         assign w_prev_acc    = g_stage[k-1].r_acc;
         assign w_prev_mcand  = g_stage[k-1].r_mcand;
         assign w_prev_mplier = g_stage[k-1].r_mplier;
      end

      // Partial product for weight 2^k, widened before the shift so nothing is lost.
      assign w_addend = w_prev_mplier[k] ? (PRODUCTLEN'(w_prev_mcand) << k) : '0;

      // Stage register: loads from predecessor on advance, holds otherwise.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_valid  <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
         end else if (w_advance) begin
            r_valid  <= w_prev_valid;
            r_acc    <= w_prev_acc + w_addend;
            r_mcand  <= w_prev_mcand;
            r_mplier <= w_prev_mplier;
         end
      end
   end

   // Occupancy: on an advancing edge one slot enters (maybe empty) and the
   // final slot leaves (emitted if it was valid), so the net change is in-out.
   logic [CNTW-1:0] r_inflight;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_inflight <= '0;
      end else if (w_advance) begin
         r_inflight <= r_inflight + CNTW'(in_valid) - CNTW'(out_valid);
      end
   end

   assign out_valid = g_stage[NSTAGE-1].r_valid;
   assign product   = g_stage[NSTAGE-1].r_acc;
   assign inflight  = r_inflight;

   // Final-stage operand copies have no consumer.
   logic w_unused_ops;
   assign w_unused_ops = ^{g_stage[NSTAGE-1].r_mcand, g_stage[NSTAGE-1].r_mplier};

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Purpose : Scoreboard bench for pipelined_multiplier; an 8x8 instance gets
//           directed latency, boundary, back-to-back, backpressure and reset
//           tests, a 4x12 instance gets randomized traffic with random stalls.
module tb_pipelined_multiplier;

   logic clk;
   logic reset;

   logic        v8, ir8, ov8, or8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic [3:0]  inf8;

   logic        v12, ir12, ov12, or12;
   logic [3:0]  a12;
   logic [11:0] b12;
   logic [15:0] p12;
   logic [3:0]  inf12;

   pipelined_multiplier #(.MULTIPLICANDLEN(8), .MULTIPLIERLEN(8)) u_dut8 (
      .clk(clk), .reset(reset), .in_valid(v8), .in_ready(ir8),
      .multiplicand(a8), .multiplier(b8), .out_valid(ov8), .out_ready(or8),
      .product(p8), .inflight(inf8));

   pipelined_multiplier #(.MULTIPLICANDLEN(4), .MULTIPLIERLEN(12)) u_dut12 (
      .clk(clk), .reset(reset), .in_valid(v12), .in_ready(ir12),
      .multiplicand(a12), .multiplier(b12), .out_valid(ov12), .out_ready(or12),
      .product(p12), .inflight(inf12));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int pops8 = 0;
   int max_inf8 = 0;
   logic [31:0] q8[$];
   logic [31:0] q12[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor for the 8x8 instance (samples at falling edge).
   initial begin : mon8
      logic        held;
      logic [15:0] held_p;
      held = 1'b0;
      held_p = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            held = 1'b0;
         end else begin
            chk("inflight8", 32'(inf8), 32'(q8.size()));
            if (held) begin
               chk("stall_valid8", 32'(ov8), 32'd1);
               chk("stall_prod8", 32'(p8), 32'(held_p));
            end
            if (ov8 && or8) begin
               if (q8.size() == 0) chk("unexpected_emit8", 32'(ov8), 32'd0);
               else chk("prod8", 32'(p8), q8.pop_front());
               pops8++;
            end
            held   = ov8 && !or8;
            held_p = p8;
            if (v8 && ir8) q8.push_back(32'(a8) * 32'(b8));
            if (int'(inf8) > max_inf8) max_inf8 = int'(inf8);
         end
      end
   end

   // Scoreboard monitor for the 4x12 instance.
   initial begin : mon12
      logic        held;
      logic [15:0] held_p;
      held = 1'b0;
      held_p = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            held = 1'b0;
         end else begin
            chk("inflight12", 32'(inf12), 32'(q12.size()));
            if (held) chk("stall_prod12", 32'(p12), 32'(held_p));
            if (ov12 && or12) begin
               if (q12.size() == 0) chk("unexpected_emit12", 32'(ov12), 32'd0);
               else chk("prod12", 32'(p12), q12.pop_front());
            end
            held   = ov12 && !or12;
            held_p = p12;
            if (v12 && ir12) q12.push_back(32'(a12) * 32'(b12));
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic drain8();
      or8 = 1'b1; v8 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (q8.size() == 0 && !ov8) break;
         tick();
      end
      chk("drain8_empty", 32'(q8.size()), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ov8"}, 32'(ov8), 32'd0);
      chk({tag, "_p8"}, 32'(p8), 32'd0);
      chk({tag, "_inf8"}, 32'(inf8), 32'd0);
      chk({tag, "_ir8"}, 32'(ir8), 32'd1);
      chk({tag, "_ov12"}, 32'(ov12), 32'd0);
      chk({tag, "_inf12"}, 32'(inf12), 32'd0);
      chk({tag, "_ir12"}, 32'(ir12), 32'd1);
   endtask

   initial begin : main
      logic [7:0] list_a[3];
      logic [7:0] list_b[3];
      logic [31:0] first_exp;
      int pops_before;

      reset = 1'b0;
      v8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
      v12 = 1'b0; a12 = '0; b12 = '0; or12 = 1'b1;
      #1 reset = 1'b1;
      #1 check_reset_outputs("reset");
      #20 reset = 1'b0;
      tick();

      // Single op, latency: the accepting edge is edge 1; valid after edge N.
      v8 = 1'b1; a8 = 8'd13; b8 = 8'd11;
      v12 = 1'b1; a12 = 4'd13; b12 = 12'd11;
      tick();
      v8 = 1'b0; v12 = 1'b0;
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         chk("lat8_valid", 32'(ov8), 32'(n == 8));
         if (n == 8) chk("lat8_prod", 32'(p8), 32'h008F);
         chk("lat12_valid", 32'(ov12), 32'(n == 12));
         if (n == 12) chk("lat12_prod", 32'(p12), 32'd143);
         tick();
      end

      fork
         begin : t8
            // Boundaries then 20 random pairs, back-to-back with no stalls.
            list_a[0] = 8'hFF; list_b[0] = 8'hFF;
            list_a[1] = 8'h00; list_b[1] = 8'hFF;
            list_a[2] = 8'hFF; list_b[2] = 8'h01;
            max_inf8 = 0;
            or8 = 1'b1;
            for (int i = 0; i < 23; i++) begin
               v8 = 1'b1;
               if (i < 3) begin a8 = list_a[i]; b8 = list_b[i]; end
               else begin a8 = 8'($urandom); b8 = 8'($urandom); end
               tick();
            end
            drain8();
            chk("b2b_max_inflight", 32'(max_inf8), 32'd8);

            // Backpressure: fill with out_ready low, stall 5 cycles, release.
            pops_before = pops8;
            or8 = 1'b0;
            first_exp = '0;
            for (int i = 0; i < 8; i++) begin
               v8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
               if (i == 0) first_exp = 32'(a8) * 32'(b8);
               tick();
            end
            for (int i = 0; i < 5; i++) begin
               a8 = 8'($urandom); b8 = 8'($urandom);
               chk("bp_in_ready", 32'(ir8), 32'd0);
               chk("bp_inflight", 32'(inf8), 32'd8);
               chk("bp_valid", 32'(ov8), 32'd1);
               chk("bp_prod", 32'(p8), first_exp);
               tick();
            end
            drain8();
            chk("bp_emitted", 32'(pops8 - pops_before), 32'd8);
         end
         begin : t12
            // Random traffic with random stalls, sweeping every multiplicand.
            for (int i = 0; i < 300; i++) begin
               v12 = ($urandom_range(0, 3) != 0);
               a12 = 4'(i);
               case ($urandom_range(0, 7))
                  0:       b12 = '0;
                  1:       b12 = '1;
                  default: b12 = 12'($urandom);
               endcase
               or12 = ($urandom_range(0, 3) != 0);
               tick();
            end
            v12 = 1'b0; or12 = 1'b1;
            for (int i = 0; i < 40; i++) begin
               if (q12.size() == 0 && !ov12) break;
               tick();
            end
            chk("drain12_empty", 32'(q12.size()), 32'd0);
         end
      join

      // Reset mid-flight with 4 ops in the 8x8 pipeline.
      or8 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         v8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
         tick();
      end
      v8 = 1'b0;
      chk("pre_reset_inflight", 32'(inf8), 32'd4);
      #2 reset = 1'b1;
      #1 check_reset_outputs("midreset");
      q8.delete();
      q12.delete();
      @(posedge clk);
      #3 reset = 1'b0;

      // First edge after reset accepts; only that op may ever emerge.
      v8 = 1'b1; a8 = 8'hA5; b8 = 8'h3C;
      tick();
      v8 = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         chk("post_reset_valid", 32'(ov8), 32'(n == 8));
         if (n == 8) chk("post_reset_prod", 32'(p8), 32'h26AC);
         tick();
      end
      chk("final_q8", 32'(q8.size()), 32'd0);
      chk("final_q12", 32'(q12.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
